mxv_result_tx: RTL

//  Result-frame transmitter for the MxV UART accelerator. Sits downstream of the MxV control FSM.

---
 rtl/mxv_result_tx_if.sv | 27 ++
 rtl/mxv_result_tx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mxv_result_tx_if.sv
// rtl/mxv_result_tx_if.sv - result buffer read port and byte-level UART TX handshake
interface mxv_result_tx_if #(
    parameter int ADDR_W = 3,
    parameter int RES_W  = 16
);
    logic [ADDR_W-1:0] rd_addr;
    logic [RES_W-1:0]  rd_data;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;

    modport master (
        output rd_addr,
        output tx_data,
        output tx_start,
        input  rd_data,
        input  tx_busy
    );

    modport slave (
        input  rd_addr,
        input  tx_data,
        input  tx_start,
        output rd_data,
        output tx_busy
    );
endinterface

// File: rtl/mxv_result_tx.sv
// rtl/mxv_result_tx.sv - serialises MxV result words as FE|LEN|CMD|payload|EF over the UART TX
module mxv_result_tx #(
    parameter int          MAX_N   = 8,
    parameter int          ADDR_W  = 3,
    parameter int          RES_W   = 16,
    parameter logic [7:0]  RSP_CMD = 8'h05
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W:0]   mat_size_i,
    mxv_result_tx_if.master   res_bus,
    output logic              busy_o,
    output logic              done_o
);

    // Byte index spans 0 .. 2*MAX_N+3
    localparam int K_W = $clog2(2 * MAX_N + 4);
    localparam logic [ADDR_W:0] N_MAX = (ADDR_W + 1)'(MAX_N);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_RD,
        ST_SEND,
        ST_GUARD,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t             state_q;
    logic               start_q;
    logic [ADDR_W:0]    n_q;
    logic [K_W-1:0]     k_q;
    logic [7:0]         word_lo_q;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic [7:0]         tx_data_q;
    logic               tx_start_q;
    logic               busy_q;
    logic               done_q;

    logic [K_W-1:0]     last_k;
    logic [K_W-1:0]     k_inc;
    logic [K_W-1:0]     inc_off;
    logic               inc_even;
    logic [ADDR_W-1:0]  inc_word;
    logic               cur_even;
    logic [7:0]         len_byte;
    logic [7:0]         byte_sel;
    logic [ADDR_W:0]    n_d;

    // Frame geometry: last byte index is 2N+3, LEN is 2N+1
    assign last_k   = K_W'({n_q, 1'b1}) + K_W'(2);
    assign len_byte = 8'({n_q, 1'b1});
    assign n_d      = (mat_size_i > N_MAX) ? N_MAX : mat_size_i;

    // Payload starts at byte 3; the even offsets (odd k) carry a word's high byte and need a buffer read
    assign cur_even = (k_q >= K_W'(3)) && (k_q < last_k) && k_q[0];
    assign k_inc    = k_q + K_W'(1);
    assign inc_off  = k_inc - K_W'(3);
    assign inc_even = (k_inc >= K_W'(3)) && (k_inc < last_k) && k_inc[0];
    assign inc_word = ADDR_W'(inc_off >> 1);

    // Bytes that do not come straight from the read port; the low byte uses the latched word
    always_comb begin
        byte_sel = word_lo_q;
        if (k_q == K_W'(0)) begin
            byte_sel = 8'hFE;
        end else if (k_q == K_W'(1)) begin
            byte_sel = len_byte;
        end else if (k_q == K_W'(2)) begin
            byte_sel = RSP_CMD;
        end else if (k_q == last_k) begin
            byte_sel = 8'hEF;
        end
    end

    // Frame sequencer; rd_addr is set on entry to PREP so the sync read lands during RD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            n_q        <= '0;
            k_q        <= '0;
            word_lo_q  <= '0;
            rd_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_q    <= start_i;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !start_q) begin
                        n_q     <= n_d;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    if (cur_even) begin
                        state_q <= ST_RD;
                    end else begin
                        tx_data_q  <= byte_sel;
                        tx_start_q <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                ST_RD: begin
                    word_lo_q  <= res_bus.rd_data[7:0];
                    tx_data_q  <= res_bus.rd_data[RES_W-1:RES_W-8];
                    tx_start_q <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    state_q <= ST_GUARD;
                end
                ST_GUARD: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!res_bus.tx_busy) begin
                        if (k_q == last_k) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            k_q <= k_inc;
                            if (inc_even) begin
                                rd_addr_q <= inc_word;
                            end
                            state_q <= ST_PREP;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_bus.rd_addr  = rd_addr_q;
    assign res_bus.tx_data  = tx_data_q;
    assign res_bus.tx_start = tx_start_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

endmodule
